// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer. It collects two 2-digit BCD operands and an
// operator, waits a programmable settle time for the external arithmetic unit,
// and then captures the result for display. A subtraction that would go negative
// moves the sequencer into an error state.
//
// state   | meaning
// ENTER_A | shifting digits into operand A
// ENTER_B | shifting digits into operand B; the operator may still change
// CALC    | operands frozen; counting down the settle time of the arithmetic unit
// SHOW    | captured result on the display
// ERR     | negative subtraction; the display shows EEEE
module calc_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic        eq_valid,
  input  logic        clr_valid,
  output logic [7:0]  operandA,
  output logic [7:0]  operandB,
  output logic [1:0]  op_sel,
  input  logic [15:0] result_in,
  output logic [15:0] display,
  output logic        busy,
  output logic        result_valid,
  output logic        error
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    CALC    = 3'd2,
    SHOW    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = SETTLE_CYCLES[3:0];
  localparam logic [1:0] OP_SUB      = 2'd2;

  state_t     state;
  logic [3:0] count;

  logic digit_ok;
  logic op_ok;
  logic take_eq;
  logic take_op;
  logic take_digit;

  // Malformed keys count as absent, so they never mask a lower-priority key.
  // Priority order: clr, then eq, then op, then digit.
  always_comb begin
    digit_ok   = digit_valid && (digit <= 4'd9);
    op_ok      = op_valid && (op_code != 2'd0);
    take_eq    = eq_valid && !clr_valid;
    take_op    = op_ok && !clr_valid && !eq_valid;
    take_digit = digit_ok && !clr_valid && !eq_valid && !op_ok;
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ENTER_A;
      operandA     <= 8'h00;
      operandB     <= 8'h00;
      op_sel       <= 2'd0;
      display      <= 16'h0000;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      count        <= 4'd0;
    end else begin
      result_valid <= 1'b0;
      if (clr_valid) begin
        state    <= ENTER_A;
        operandA <= 8'h00;
        operandB <= 8'h00;
        op_sel   <= 2'd0;
        display  <= 16'h0000;
        busy     <= 1'b0;
        error    <= 1'b0;
        count    <= 4'd0;
      end else begin
        case (state)
          ENTER_A: begin
            if (take_op) begin
              op_sel   <= op_code;
              operandB <= 8'h00;
              display  <= 16'h0000;
              state    <= ENTER_B;
            end else if (take_digit) begin
              operandA <= {operandA[3:0], digit};
              display  <= {8'h00, operandA[3:0], digit};
            end
          end
          ENTER_B: begin
            if (take_eq) begin
              count <= SETTLE_LOAD;
              busy  <= 1'b1;
              state <= CALC;
            end else if (take_op) begin
              op_sel <= op_code;
            end else if (take_digit) begin
              operandB <= {operandB[3:0], digit};
              display  <= {8'h00, operandB[3:0], digit};
            end
          end
          CALC: begin
            if (count == 4'd1) begin
              count <= 4'd0;
              busy  <= 1'b0;
              // The operands are packed BCD, so a plain binary compare orders them correctly.
              if ((op_sel == OP_SUB) && (operandA < operandB)) begin
                error   <= 1'b1;
                display <= 16'hEEEE;
                state   <= ERR;
              end else begin
                display      <= result_in;
                result_valid <= 1'b1;
                state        <= SHOW;
              end
            end else begin
              count <= count - 4'd1;
            end
          end
          SHOW: begin
            if (take_digit) begin
              operandA <= {4'h0, digit};
              operandB <= 8'h00;
              op_sel   <= 2'd0;
              display  <= {12'h000, digit};
              state    <= ENTER_A;
            end
          end
          ERR: begin
            if (take_digit) begin
              state    <= ENTER_A;
              operandA <= 8'h00;
              operandB <= 8'h00;
              op_sel   <= 2'd0;
              display  <= 16'h0000;
              busy     <= 1'b0;
              error    <= 1'b0;
              count    <= 4'd0;
            end
          end
          default: begin
            state <= ENTER_A;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, which sets the number of clock edges between accepting equals and capturing the datapath result (legal range 1-15).
REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- digit_valid  input  1  one-cycle strobe; digit key pressed.
- digit  input  4  BCD digit value.
- op_valid  input  1  one-cycle strobe; operator key pressed.
- op_code  input  2  operator: 1 = add, 2 = sub, 3 = mul, 0 = reserved.
- eq_valid  input  1  one-cycle strobe; equals key pressed.
- clr_valid  input  1  one-cycle strobe; clear key pressed.
- operandA  output  8  two-digit BCD operand A, to the arithmetic unit.
- operandB  output  8  two-digit BCD operand B, to the arithmetic unit.
- op_sel  output  2  operator select, to the arithmetic unit.
- result_in  input  16  four-digit BCD result, from the arithmetic unit.
- display  output  16  four BCD digits to the 7-segment driver.
- busy  output  1  high while in CALC.
- result_valid  output  1  one-cycle pulse when a result is captured.
- error  output  1  high while in ERR.

Function
REQ-003 SHALL implement an FSM with states ENTER_A, ENTER_B, CALC, SHOW and ERR; the reset state is ENTER_A.
REQ-004 SHALL apply same-cycle strobe priority clr > eq > op > digit; only the highest-priority strobe present in a cycle takes effect.
REQ-005 SHALL ignore any digit_valid where digit > 9, and any op_valid where op_code == 0.
REQ-006 ENTER_A, on digit d: SHALL set operandA <= {operandA[3:0], d}; the oldest digit is discarded.
REQ-007 ENTER_A, on op: SHALL set op_sel <= op_code and operandB <= 0, then go to ENTER_B.
REQ-008 ENTER_A: SHALL ignore eq.
REQ-009 ENTER_B, on digit d: SHALL set operandB <= {operandB[3:0], d}.
REQ-010 ENTER_B, on op: SHALL replace op_sel and stay in ENTER_B.
REQ-011 ENTER_B, on eq: SHALL load the settle counter with SETTLE_CYCLES and go to CALC.
REQ-012 CALC: SHALL hold operandA, operandB and op_sel stable and drive busy = 1.
REQ-013 CALC: SHALL ignore digit, op and eq strobes; clr remains effective.
REQ-014 CALC: SHALL decrement the counter on each edge and capture the result on the edge where the counter equals 1, i.e. the SETTLE_CYCLES-th edge after the edge that accepted eq.
REQ-015 Capture, when op_sel == 2 and operandA < operandB (binary compare of the BCD bytes): SHALL go to ERR and leave result_valid low.
REQ-016 Capture, otherwise: SHALL set display <= result_in, pulse result_valid high for exactly the next cycle, and go to SHOW.
REQ-017 SHOW, on digit d: SHALL set operandA <= {4'h0, d}, operandB <= 0, op_sel <= 0, and go to ENTER_A.
REQ-018 SHOW: SHALL ignore op and eq.
REQ-019 ERR: SHALL drive display = 16'hEEEE and error = 1.
REQ-020 ERR: SHALL treat a digit or clr as a full clear to reset values and return to ENTER_A; the digit is not entered.
REQ-021 clr, in any state: SHALL synchronously restore all outputs and the state to their reset values.
REQ-022 Display: SHALL show {8'h00, operandA} in ENTER_A and {8'h00, operandB} in ENTER_B; it SHALL hold its last value in CALC and SHOW.
REQ-023 result_in: SHALL be treated as combinational from operandA/operandB/op_sel and sampled only at the capture edge.

Reset
REQ-024 rst_n low SHALL asynchronously force state = ENTER_A, operandA = 0, operandB = 0, op_sel = 0, display = 0, busy = 0, result_valid = 0, error = 0, counter = 0.
REQ-025 Reset asserted mid-CALC SHALL abort the calculation with no result_valid pulse.
REQ-026 After rst_n deasserts, strobes SHALL be honoured from the first rising edge.

Verification
REQ-027 Sequence 4, 2, op=1, 7, eq with SETTLE_CYCLES = 1 -> capture one edge after eq; display = 16'h0049; result_valid pulses for 1 cycle; state SHOW.
REQ-028 Sequence 9, 9, op=3, 9, 9, eq -> display = 16'h9801; error = 0.
REQ-029 Sequence 1, 2, op=2, 3, 4, eq -> error = 1; display = 16'hEEEE; no result_valid; then clr -> all outputs 0.
REQ-030 Digits 1, 2, 3, then digit = 4'hA in ENTER_A -> operandA = 8'h23; display = 16'h0023.
REQ-031 digit_valid and op_valid in the same cycle in ENTER_A -> op taken, digit dropped, state ENTER_B; eq strobed during CALC -> ignored.
REQ-032 With SETTLE_CYCLES = 3, rst_n pulled low 2 edges after eq -> all outputs 0 immediately; result_valid never pulses.
